data_retire_unit: RTL and testbench

Downstream consumer of the data manager. It accepts each sent beat (data plus id) into an id-indexed tracking table and collects out-of-order completion status from the execution side. It retires entries strictly in id order by advancing `retire_ptr`. When the oldest entry completes with a failure, it issues a one-cycle abort that rewinds the data manager to that id and replays its stored data.

---
 rtl/dm_pkg.sv | 26 ++
 rtl/dm_retire_scan.sv | 39 +++
 rtl/data_retire_unit.sv | 148 ++++++++++++++
 tb/tb_data_retire_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared constants, pointer type, FSM encoding and pointer wrap helper
// for the data manager / retire unit pair.
package dm_pkg;

  localparam int DM_DEPTH      = 48;
  localparam int DM_DATA_WIDTH = 32;
  localparam int DM_PTR_W      = $clog2(DM_DEPTH);

  typedef logic [DM_PTR_W-1:0] ptr_t;

  typedef enum logic {
    RUN   = 1'b0,
    ABORT = 1'b1
  } dm_state_e;

  // Modular add for the default table depth; n must not exceed DM_DEPTH.
  function automatic ptr_t ptr_add(ptr_t ptr, logic [DM_PTR_W:0] n);
    logic [DM_PTR_W:0] sum;
    sum = {1'b0, ptr} + n;
    if (sum >= (DM_PTR_W+1)'(DM_DEPTH)) begin
      sum = sum - (DM_PTR_W+1)'(DM_DEPTH);
    end
    return sum[DM_PTR_W-1:0];
  endfunction

endpackage

// File: rtl/dm_retire_scan.sv
// Combinational scan from the retire pointer: counts the in-order run of
// successfully completed entries (capped) and flags a failed head entry.
module dm_retire_scan
  import dm_pkg::*;
#(
  parameter int DEPTH    = DM_DEPTH,
  parameter int RETIRE_W = 4,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int KW      = $clog2(RETIRE_W + 1)
) (
  input  logic [DEPTH-1:0] vld,
  input  logic [DEPTH-1:0] done,
  input  logic [DEPTH-1:0] ok,
  input  logic [PTR_W-1:0] retire_ptr,
  output logic [KW-1:0]    k,
  output logic             head_fail
);

  logic [PTR_W-1:0] idx;
  logic             run;

  // The run stops at the first entry that is not valid, done and ok.
  always_comb begin
    k   = '0;
    run = 1'b1;
    idx = retire_ptr;
    for (int i = 0; i < RETIRE_W; i++) begin
      if (run && vld[idx] && done[idx] && ok[idx]) begin
        k = k + KW'(1);
      end else begin
        run = 1'b0;
      end
      idx = (idx == PTR_W'(DEPTH - 1)) ? '0 : idx + PTR_W'(1);
    end
  end

  assign head_fail = vld[retire_ptr] & done[retire_ptr] & ~ok[retire_ptr];

endmodule

// File: rtl/data_retire_unit.sv
// Id-indexed tracking table that retires beats in id order and requests a
// one-cycle rewind when the oldest entry completes with a failure.
module data_retire_unit
  import dm_pkg::*;
#(
  parameter int DEPTH      = DM_DEPTH,
  parameter int DATA_WIDTH = DM_DATA_WIDTH,
  parameter int RETIRE_W   = 4,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int KW        = $clog2(RETIRE_W + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [PTR_W-1:0]      id_i,
  input  logic                  cmpl_vld,
  input  logic [PTR_W-1:0]      cmpl_id,
  input  logic                  cmpl_ok,
  output logic [PTR_W-1:0]      retire_ptr,
  output logic                  abort_vld,
  output logic [PTR_W-1:0]      abort_id,
  output logic [DATA_WIDTH-1:0] abort_data,
  output logic                  err_o
);

  dm_state_e             state_q, state_d;
  logic [DEPTH-1:0]      vld_q, done_q, ok_q;
  logic [DEPTH-1:0]      vld_d, done_d, ok_d;
  logic [DEPTH-1:0]      retire_mask;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]      retire_ptr_q, ptr_next, mask_idx;
  logic [PTR_W:0]        ptr_sum;
  logic [PTR_W-1:0]      abort_id_q;
  logic [DATA_WIDTH-1:0] abort_data_q;
  logic                  err_q;
  logic [KW-1:0]         k;
  logic                  head_fail;
  logic                  accept;
  logic                  cmpl_take;

  dm_retire_scan #(
    .DEPTH    (DEPTH),
    .RETIRE_W (RETIRE_W)
  ) u_scan (
    .vld        (vld_q),
    .done       (done_q),
    .ok         (ok_q),
    .retire_ptr (retire_ptr_q),
    .k          (k),
    .head_fail  (head_fail)
  );

  assign ready_o = (state_q == RUN);
  assign accept  = valid_i && (state_q == RUN);
  // A completion racing the write of its own entry is dropped.
  assign cmpl_take = (state_q == RUN) && cmpl_vld && vld_q[cmpl_id] &&
                     !(accept && (id_i == cmpl_id));

  always_comb begin
    retire_mask = '0;
    mask_idx    = retire_ptr_q;
    for (int i = 0; i < RETIRE_W; i++) begin
      if (i < int'(k)) begin
        retire_mask[mask_idx] = 1'b1;
      end
      mask_idx = (mask_idx == PTR_W'(DEPTH - 1)) ? '0 : mask_idx + PTR_W'(1);
    end
  end

  always_comb begin
    ptr_sum  = {1'b0, retire_ptr_q} + (PTR_W+1)'(k);
    ptr_next = (ptr_sum >= (PTR_W+1)'(DEPTH)) ?
               PTR_W'(ptr_sum - (PTR_W+1)'(DEPTH)) : ptr_sum[PTR_W-1:0];
  end

  // Next table state: the abort cycle flushes, otherwise complete/retire/accept.
  always_comb begin
    vld_d  = vld_q;
    done_d = done_q;
    ok_d   = ok_q;
    if (state_q == ABORT) begin
      vld_d = '0;
    end else begin
      if (cmpl_take) begin
        done_d[cmpl_id] = 1'b1;
        ok_d[cmpl_id]   = cmpl_ok;
      end
      vld_d = vld_d & ~retire_mask;
      if (accept) begin
        vld_d[id_i]  = 1'b1;
        done_d[id_i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (head_fail) state_d = ABORT;
      ABORT:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      vld_q        <= '0;
      done_q       <= '0;
      ok_q         <= '0;
      retire_ptr_q <= '0;
      abort_id_q   <= '0;
      abort_data_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      if (state_q == RUN) begin
        retire_ptr_q <= ptr_next;
      end
      if ((state_q == RUN) && head_fail) begin
        abort_id_q   <= retire_ptr_q;
        abort_data_q <= data_q[retire_ptr_q];
      end
      if (accept && vld_q[id_i]) begin
        err_q <= 1'b1;
      end
    end
  end

  // Payload storage carries no reset; only valid entries are ever read.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q[id_i] <= data_i;
    end
  end

  assign retire_ptr = retire_ptr_q;
  assign abort_vld  = (state_q == ABORT);
  assign abort_id   = abort_id_q;
  assign abort_data = abort_data_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_data_retire_unit.sv
// Self-checking bench for data_retire_unit: directed scenarios plus random
// traffic, all compared every cycle against a table-level reference model.
module tb_data_retire_unit;

  localparam int DEPTH = 48;
  localparam int DW    = 32;
  localparam int RW    = 4;
  localparam int PW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] data_i;
  logic [PW-1:0] id_i;
  logic          cmpl_vld;
  logic [PW-1:0] cmpl_id;
  logic          cmpl_ok;
  logic [PW-1:0] retire_ptr;
  logic          abort_vld;
  logic [PW-1:0] abort_id;
  logic [DW-1:0] abort_data;
  logic          err_o;

  always #5 clk = ~clk;

  data_retire_unit #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW),
    .RETIRE_W   (RW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_i     (data_i),
    .id_i       (id_i),
    .cmpl_vld   (cmpl_vld),
    .cmpl_id    (cmpl_id),
    .cmpl_ok    (cmpl_ok),
    .retire_ptr (retire_ptr),
    .abort_vld  (abort_vld),
    .abort_id   (abort_id),
    .abort_data (abort_data),
    .err_o      (err_o)
  );

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: one record per id plus the retire pointer and abort flag.
  bit          m_vld  [DEPTH];
  bit          m_done [DEPTH];
  bit          m_ok   [DEPTH];
  logic [31:0] m_data [DEPTH];
  int          m_ptr;
  bit          m_abort;
  bit          m_err;
  int          m_abort_id;
  logic [31:0] m_abort_data;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic modelStep(input bit rst, input bit v, input int id, input logic [31:0] d,
                           input bit cv, input int cid, input bit cok);
    int  k;
    bit  hf;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_vld[i] = 0; m_done[i] = 0; m_ok[i] = 0;
      end
      m_ptr = 0; m_abort = 0; m_err = 0; m_abort_id = 0; m_abort_data = 0;
    end else if (m_abort) begin
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
      m_abort = 0;
    end else begin
      hf = m_vld[m_ptr] && m_done[m_ptr] && !m_ok[m_ptr];
      k = 0;
      while (k < RW && m_vld[(m_ptr + k) % DEPTH] && m_done[(m_ptr + k) % DEPTH] &&
             m_ok[(m_ptr + k) % DEPTH]) k++;
      if (hf) begin
        m_abort = 1; m_abort_id = m_ptr; m_abort_data = m_data[m_ptr];
      end
      if (v && m_vld[id]) m_err = 1;
      if (cv && m_vld[cid] && !(v && id == cid)) begin
        m_done[cid] = 1; m_ok[cid] = cok;
      end
      for (int j = 0; j < k; j++) m_vld[(m_ptr + j) % DEPTH] = 0;
      if (v) begin
        m_vld[id] = 1; m_done[id] = 0; m_data[id] = d;
      end
      m_ptr = (m_ptr + k) % DEPTH;
    end
  endtask

  task automatic compareAll();
    checkOutput("ready_o", ready_o, !m_abort);
    checkOutput("abort_vld", abort_vld, m_abort);
    checkOutput("retire_ptr", retire_ptr, m_ptr);
    checkOutput("err_o", err_o, m_err);
    checkOutput("abort_id", abort_id, m_abort_id);
    checkOutput("abort_data", abort_data, m_abort_data);
  endtask

  // Drive one cycle of inputs, advance model at the edge, compare just after it.
  task automatic applyStimulus(input bit rst, input bit v, input int id, input logic [31:0] d,
                               input bit cv, input int cid, input bit cok);
    reset = rst; valid_i = v; id_i = PW'(id); data_i = d;
    cmpl_vld = cv; cmpl_id = PW'(cid); cmpl_ok = cok;
    @(posedge clk);
    modelStep(rst, v && !m_abort, id, d, cv, cid, cok);
    #1;
    compareAll();
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic idle();                                 applyStimulus(0, 0, 0, 0, 0, 0, 0);  endtask
  task automatic send(input int id, input logic [31:0] d); applyStimulus(0, 1, id, d, 0, 0, 0); endtask
  task automatic cmpl(input int id, input bit ok);       applyStimulus(0, 0, 0, 0, 1, id, ok); endtask

  task automatic waitAbort();
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      idle();
      if (abort_vld) seen = 1;
    end
    checkOutput("abort_timeout", seen, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int wr;
    bit v, cv, cok;
    int cid;

    // Reset state
    doReset();
    checkOutput("rst_ready", ready_o, 1);
    checkOutput("rst_ptr", retire_ptr, 0);
    checkOutput("rst_abort", abort_vld, 0);

    // In-order retire
    for (int i = 0; i < 4; i++) send(i, 32'h10 + i);
    for (int i = 0; i < 4; i++) cmpl(i, 1);
    repeat (3) idle();
    checkOutput("inorder_ptr", retire_ptr, 4);
    checkOutput("inorder_err", err_o, 0);

    // Out-of-order completion
    doReset();
    for (int i = 0; i < 3; i++) send(i, 32'h20 + i);
    cmpl(2, 1); cmpl(1, 1); cmpl(0, 1);
    checkOutput("ooo_hold", retire_ptr, 0);
    idle();
    checkOutput("ooo_jump", retire_ptr, 3);

    // Retire cap
    doReset();
    for (int i = 0; i < 6; i++) send(i, 32'h30 + i);
    for (int i = 5; i >= 1; i--) cmpl(i, 1);
    cmpl(0, 1);
    checkOutput("cap_hold", retire_ptr, 0);
    idle();
    checkOutput("cap_first", retire_ptr, 4);
    idle();
    checkOutput("cap_second", retire_ptr, 6);

    // Fail at id 6, flush, late ok for 7 dropped, replay of 6
    doReset();
    for (int i = 0; i < 9; i++) send(i, (i < 5) ? 32'(i) : 32'hA0 + i);
    for (int i = 0; i < 6; i++) cmpl(i, 1);
    cmpl(8, 1);
    cmpl(6, 0);
    waitAbort();
    checkOutput("fail_abort_id", abort_id, 6);
    checkOutput("fail_abort_data", abort_data, 32'hA6);
    checkOutput("fail_ready", ready_o, 0);
    checkOutput("fail_ptr", retire_ptr, 6);
    cmpl(7, 1);
    applyStimulus(0, 1, 6, 32'hA6, 1, 7, 1);
    checkOutput("replay_ready", ready_o, 1);
    cmpl(6, 1);
    repeat (2) idle();
    checkOutput("replay_ptr", retire_ptr, 7);

    // Wrap from 46 across the end of the table
    doReset();
    for (int i = 0; i < 46; i++) applyStimulus(0, 1, i, i, i > 0, i - 1, 1);
    cmpl(45, 1);
    repeat (3) idle();
    checkOutput("wrap_start", retire_ptr, 46);
    send(46, 32'h46); send(47, 32'h47); send(0, 32'h100); send(1, 32'h101);
    cmpl(47, 1); cmpl(0, 1); cmpl(1, 1);
    cmpl(46, 1);
    checkOutput("wrap_hold", retire_ptr, 46);
    idle();
    checkOutput("wrap_ptr", retire_ptr, 2);

    // Resend of a valid id raises a sticky error
    doReset();
    send(3, 32'h33);
    send(3, 32'h34);
    checkOutput("err_set", err_o, 1);
    repeat (2) idle();
    checkOutput("err_sticky", err_o, 1);

    // Reset during ABORT
    doReset();
    send(0, 32'h1); send(0, 32'h2); cmpl(0, 1);
    send(1, 32'h77); cmpl(1, 0);
    waitAbort();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("rstab_abort", abort_vld, 0);
    checkOutput("rstab_ptr", retire_ptr, 0);
    checkOutput("rstab_err", err_o, 0);
    checkOutput("rstab_ready", ready_o, 1);

    // Random traffic shaped like a well-behaved data manager
    doReset();
    wr = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(199) == 0) begin
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        wr = 0;
      end else begin
        if (m_abort) wr = m_abort_id;
        v   = ($urandom_range(9) < 6) && !m_vld[wr];
        cv  = $urandom_range(1) == 1;
        cid = (m_ptr + $urandom_range(7)) % DEPTH;
        cok = $urandom_range(5) != 0;
        if (v && !m_abort) begin
          applyStimulus(0, 1, wr, $urandom, cv, cid, cok);
          wr = (wr + 1) % DEPTH;
        end else begin
          applyStimulus(0, v, wr, $urandom, cv, cid, cok);
        end
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
